// File: rtl/uart_receiver_param.sv
// uart_receiver_param: oversampling UART receiver with 2-of-3 majority sampling, false-start
// rejection and framing/break/parity status. Optional parity stage: `UART_RX_PARITY_EN.
module uart_receiver_param #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 break_detect,
  output logic                 parity_error
);

  localparam int unsigned TICK_DEN = BAUD_RATE * OVERSAMPLE;
  localparam int unsigned DIV_RAW  = (CLK_FREQ + TICK_DEN / 2) / TICK_DEN;
  localparam int unsigned DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TICK_W   = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W    = $clog2(DATA_BITS);
  localparam int unsigned SAMP_A   = OVERSAMPLE / 2 - 1;
  localparam int unsigned SAMP_B   = OVERSAMPLE / 2;
  localparam int unsigned SAMP_C   = OVERSAMPLE / 2 + 1;

  if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0 ||
      DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY > 2) begin : g_bad_cfg
    $error("uart_receiver_param: illegal parameter set");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;
  localparam bit PAR_ON  = (PARITY != 0);
  localparam bit PAR_ODD = (PARITY == 2);
`else
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_rx_sync;
  logic [DIV_W-1:0]     r_div;
  logic [TICK_W-1:0]    r_tick;
  logic                 r_s1;
  logic                 r_s2;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_stop_cnt;
  logic                 r_stop_low;
  logic                 r_first_low;
  logic                 r_par_err;

  logic w_rx_s;
  logic w_tick;
  logic w_samp_a;
  logic w_samp_b;
  logic w_resolve;
  logic w_vote;
  logic w_last_stop;
  logic w_stop_bad;
  logic w_first_low;
  logic w_done;
  logic w_fe_nxt;
  logic w_bd_nxt;
  logic w_pe_nxt;

  assign w_rx_s      = r_rx_sync[2];
  assign w_tick      = (r_div == DIV_W'(DIV - 1));
  assign w_samp_a    = w_tick && (r_tick == TICK_W'(SAMP_A));
  assign w_samp_b    = w_tick && (r_tick == TICK_W'(SAMP_B));
  assign w_resolve   = w_tick && (r_tick == TICK_W'(SAMP_C));
  assign w_vote      = (r_s1 & r_s2) | (r_s1 & w_rx_s) | (r_s2 & w_rx_s);
  assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
  assign w_stop_bad  = r_stop_low | ~w_vote;
  assign w_first_low = (r_stop_cnt == 1'b0) ? ~w_vote : r_first_low;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rx_sync <= 3'b111;
    else       r_rx_sync <= {r_rx_sync[1:0], rx};
  end

  // Counters sit at zero while idle so tick 0 starts on the synchronised falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div  <= '0;
      r_tick <= '0;
    end else if (r_state == S_IDLE) begin
      r_div  <= '0;
      r_tick <= '0;
    end else if (w_tick) begin
      r_div  <= '0;
      r_tick <= (r_tick == TICK_W'(OVERSAMPLE - 1)) ? '0 : r_tick + TICK_W'(1);
    end else begin
      r_div  <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (!w_rx_s) w_state_nxt = S_START;
      S_START:     if (w_resolve) w_state_nxt = w_vote ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_resolve && (r_idx == IDX_W'(DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = PAR_ON ? S_PARITY : S_STOP;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY:    if (w_resolve) w_state_nxt = S_STOP;
`endif
      S_STOP:      if (w_resolve && w_last_stop) w_state_nxt = w_stop_bad ? S_WAIT_IDLE : S_IDLE;
      S_WAIT_IDLE: if (w_rx_s) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_done   = 1'b0;
    w_fe_nxt = 1'b0;
    w_bd_nxt = 1'b0;
    w_pe_nxt = 1'b0;
    if ((r_state == S_STOP) && w_resolve && w_last_stop) begin
      w_done   = 1'b1;
      w_fe_nxt = w_stop_bad;
      w_bd_nxt = (r_shift == '0) && w_first_low;
      w_pe_nxt = r_par_err;
    end
  end

  // Sample shift register and per-frame stop status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1        <= 1'b1;
      r_s2        <= 1'b1;
      r_idx       <= '0;
      r_shift     <= '0;
      r_stop_cnt  <= 1'b0;
      r_stop_low  <= 1'b0;
      r_first_low <= 1'b0;
    end else begin
      if (w_samp_a) r_s1 <= w_rx_s;
      if (w_samp_b) r_s2 <= w_rx_s;
      case (r_state)
        S_IDLE: begin
          r_idx       <= '0;
          r_stop_cnt  <= 1'b0;
          r_stop_low  <= 1'b0;
          r_first_low <= 1'b0;
        end
        S_DATA: begin
          if (w_resolve) begin
            r_shift[r_idx] <= w_vote;
            r_idx          <= r_idx + IDX_W'(1);
          end
        end
        S_STOP: begin
          if (w_resolve) begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
            r_stop_low <= w_stop_bad;
            if (r_stop_cnt == 1'b0) r_first_low <= ~w_vote;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par_err <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_par_err <= 1'b0;
    end else if ((r_state == S_PARITY) && w_resolve) begin
      r_par_err <= w_vote ^ (^r_shift) ^ PAR_ODD;
    end
  end
`else
  assign r_par_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data          <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      break_detect  <= 1'b0;
      parity_error  <= 1'b0;
    end else begin
      data_ready    <= w_done;
      framing_error <= w_fe_nxt;
      break_detect  <= w_bd_nxt;
      parity_error  <= w_pe_nxt;
      if (w_done) data <= r_shift;
    end
  end

endmodule

// File: tb/tb_uart_receiver_param.sv
// Directed bench for uart_receiver_param: 16 clk/bit, 8N1 and 5-data/2-stop instances.
module tb_uart_receiver_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_a, rx_b, rx_c;
  logic [7:0] a_data;
  logic       a_rdy, a_fe, a_bd, a_pe;
  logic [4:0] b_data;
  logic       b_rdy, b_fe, b_bd, b_pe;
  logic [7:0] c_data;
  logic       c_rdy, c_fe, c_bd, c_pe;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_receiver_param #(
    .CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY(0)
  ) u_dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .data(a_data), .data_ready(a_rdy),
    .framing_error(a_fe), .break_detect(a_bd), .parity_error(a_pe)
  );

  uart_receiver_param #(
    .CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
    .DATA_BITS(5), .STOP_BITS(2), .PARITY(0)
  ) u_dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .data(b_data), .data_ready(b_rdy),
    .framing_error(b_fe), .break_detect(b_bd), .parity_error(b_pe)
  );

`ifdef UART_RX_PARITY_EN
  uart_receiver_param #(
    .CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY(1)
  ) u_dut_c (
    .clk(clk), .reset(reset), .rx(rx_c), .data(c_data), .data_ready(c_rdy),
    .framing_error(c_fe), .break_detect(c_bd), .parity_error(c_pe)
  );
`else
  assign c_data = '0;
  assign {c_rdy, c_fe, c_bd, c_pe} = 4'b0000;
`endif

  // Pulse monitors: capture payload, flags {fe,bd,pe} and latency from start-bit drive.
  int a_pulses = 0, a_start = 0, a_lat = 0;
  int b_pulses = 0, b_start = 0, b_lat = 0;
  int c_pulses = 0;
  logic [7:0] a_cap = '0, c_cap = '0;
  logic [4:0] b_cap = '0;
  logic [2:0] a_flags = '0, b_flags = '0, c_flags = '0;

  always @(negedge clk) begin
    if (a_rdy) begin
      a_pulses++; a_cap = a_data; a_flags = {a_fe, a_bd, a_pe}; a_lat = cyc - a_start;
    end
    if (b_rdy) begin
      b_pulses++; b_cap = b_data; b_flags = {b_fe, b_bd, b_pe}; b_lat = cyc - b_start;
    end
    if (c_rdy) begin
      c_pulses++; c_cap = c_data; c_flags = {c_fe, c_bd, c_pe};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v);
    case (sel)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serialise n bits LSB first, 16 clocks each, then return the line high.
  task automatic send(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (sel == 0) a_start = cyc;
        else if (sel == 1) b_start = cyc;
      end
      drive(sel, bits[i]);
      repeat (15) @(negedge clk);
    end
    @(negedge clk);
    drive(sel, 1'b1);
  endtask

  int p;

  initial begin
    reset = 1'b1;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    rx_c  = 1'b1;
    idle(3);
    check("rst_data", a_data, 8'h00);
    check("rst_rdy", a_rdy, 1'b0);
    check("rst_flags", {a_fe, a_bd, a_pe}, 3'b000);
    reset = 1'b0;
    idle(10);

    // Clean 8N1 frame and its latency
    p = a_pulses;
    send(0, {1'b1, 8'hA5, 1'b0}, 10);
    idle(30);
    check("a5_pulses", a_pulses - p, 1);
    check("a5_data", a_cap, 8'hA5);
    check("a5_flags", a_flags, 3'b000);
    check("a5_latency", a_lat, 158);

    // Short glitch is rejected; data holds
    p = a_pulses;
    @(negedge clk); rx_a = 1'b0;
    idle(4);        rx_a = 1'b1;
    idle(40);
    check("glitch_pulses", a_pulses - p, 0);
    check("glitch_hold", a_data, 8'hA5);
    p = a_pulses;
    send(0, {1'b1, 8'h3C, 1'b0}, 10);
    idle(30);
    check("3c_pulses", a_pulses - p, 1);
    check("3c_data", a_cap, 8'h3C);
    check("3c_flags", a_flags, 3'b000);

    // Stop bit low
    p = a_pulses;
    send(0, {1'b0, 8'h55, 1'b0}, 10);
    idle(40);
    check("fe_pulses", a_pulses - p, 1);
    check("fe_data", a_cap, 8'h55);
    check("fe_flags", a_flags, 3'b100);

    // Line held low for 40 bit times
    p = a_pulses;
    @(negedge clk); rx_a = 1'b0;
    idle(640);      rx_a = 1'b1;
    idle(40);
    check("brk_pulses", a_pulses - p, 1);
    check("brk_data", a_cap, 8'h00);
    check("brk_flags", a_flags, 3'b110);
    p = a_pulses;
    send(0, {1'b1, 8'h81, 1'b0}, 10);
    idle(30);
    check("81_pulses", a_pulses - p, 1);
    check("81_data", a_cap, 8'h81);
    check("81_flags", a_flags, 3'b000);

    // Reset in the middle of 0xFF data bits
    p = a_pulses;
    @(negedge clk); rx_a = 1'b0;
    idle(16);       rx_a = 1'b1;
    idle(48);       reset = 1'b1;
    idle(1);        reset = 1'b0;
    check("rst_mid_data", a_data, 8'h00);
    idle(200);
    check("rst_mid_pulses", a_pulses - p, 0);
    p = a_pulses;
    send(0, {1'b1, 8'h12, 1'b0}, 10);
    idle(30);
    check("12_pulses", a_pulses - p, 1);
    check("12_data", a_cap, 8'h12);
    check("12_flags", a_flags, 3'b000);

    // 5 data bits, 2 stop bits
    p = b_pulses;
    send(1, {2'b11, 5'h1B, 1'b0}, 8);
    idle(30);
    check("b1b_pulses", b_pulses - p, 1);
    check("b1b_data", b_cap, 5'h1B);
    check("b1b_flags", b_flags, 3'b000);
    check("b1b_latency", b_lat, 126);
    p = b_pulses;
    send(1, {2'b01, 5'h0A, 1'b0}, 8);
    idle(40);
    check("b_stop2_pulses", b_pulses - p, 1);
    check("b_stop2_data", b_cap, 5'h0A);
    check("b_stop2_flags", b_flags, 3'b100);
    p = b_pulses;
    send(1, {2'b10, 5'h00, 1'b0}, 8);
    idle(40);
    check("b_stop1_pulses", b_pulses - p, 1);
    check("b_stop1_data", b_cap, 5'h00);
    check("b_stop1_flags", b_flags, 3'b110);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, parity bit 1
    p = c_pulses;
    send(2, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    idle(30);
    check("par_ok_pulses", c_pulses - p, 1);
    check("par_ok_data", c_cap, 8'h07);
    check("par_ok_flags", c_flags, 3'b000);
    p = c_pulses;
    send(2, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
    idle(30);
    check("par_bad_pulses", c_pulses - p, 1);
    check("par_bad_flags", c_flags, 3'b001);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
